// File: rtl/vx_fifo_pop_stage.sv
// Drains a FIFO head into a registered valid/ready stream through a 2-entry skid buffer; pop-to-valid latency 1 cycle.
// fifo_pop depends only on registered state, never on ready_out. Optional stall counter: VX_POP_STAGE_PERF_EN.
module vx_fifo_pop_stage #(
  parameter int DATAW  = 1,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [DATAW-1:0]  fifo_data,
  output logic              fifo_pop,
  input  logic              flush,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [DATAW-1:0]  data_out,
`ifdef VX_POP_STAGE_PERF_EN
  output logic [PERF_W-1:0] stall_cnt,
`endif
  output logic [1:0]        count
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DATAW-1:0] r_head;
  logic [DATAW-1:0] r_spare;
  logic             w_fire;
  logic             w_ld_head;
  logic             w_head_from_spare;
  logic             w_ld_spare;

  assign fifo_pop  = !fifo_empty && (r_state != S_TWO) && !flush && reset;
  assign valid_out = (r_state != S_EMPTY);
  assign w_fire    = valid_out && ready_out;
  assign data_out  = r_head;
  assign count     = r_state;

  always_comb begin
    w_state_nxt       = r_state;
    w_ld_head         = 1'b0;
    w_head_from_spare = 1'b0;
    w_ld_spare        = 1'b0;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (fifo_pop) begin
            w_state_nxt = S_ONE;
            w_ld_head   = 1'b1;
          end
        end
        S_ONE: begin
          if (fifo_pop && w_fire) begin
            w_ld_head = 1'b1;
          end else if (fifo_pop) begin
            w_state_nxt = S_TWO;
            w_ld_spare  = 1'b1;
          end else if (w_fire) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_TWO: begin
          // The spare always holds the older-than-FIFO item, so it moves up on a fire.
          if (w_fire) begin
            w_state_nxt       = S_ONE;
            w_ld_head         = 1'b1;
            w_head_from_spare = 1'b1;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_EMPTY;
      r_head  <= '0;
      r_spare <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ld_head) begin
        r_head <= w_head_from_spare ? r_spare : fifo_data;
      end
      if (w_ld_spare) begin
        r_spare <= fifo_data;
      end
      assert (!(fifo_pop && fifo_empty));
      assert (count <= 2'd2);
      assert (PERF_W > 0);
    end
  end

`ifdef VX_POP_STAGE_PERF_EN
  logic [PERF_W-1:0] r_stall_cnt;

  // Survives flush on purpose: it measures consumer back-pressure, not buffer contents.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (valid_out && !ready_out) begin
      r_stall_cnt <= r_stall_cnt + PERF_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_vx_fifo_pop_stage.sv
// Bench for vx_fifo_pop_stage: directed scenarios then random traffic against a queue-based model.
module tb_vx_fifo_pop_stage;

  localparam int DATAW  = 8;
  localparam int PERF_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             fifo_empty;
  logic [DATAW-1:0] fifo_data;
  logic             fifo_pop;
  logic             flush;
  logic             valid_out;
  logic             ready_out;
  logic [DATAW-1:0] data_out;
  logic [1:0]       count;
`ifdef VX_POP_STAGE_PERF_EN
  logic [PERF_W-1:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  vx_fifo_pop_stage #(.DATAW(DATAW), .PERF_W(PERF_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_pop   (fifo_pop),
    .flush      (flush),
    .valid_out  (valid_out),
    .ready_out  (ready_out),
    .data_out   (data_out),
`ifdef VX_POP_STAGE_PERF_EN
    .stall_cnt  (stall_cnt),
`endif
    .count      (count)
  );

  // Model: the source FIFO contents, and the items taken from it but not yet delivered.
  logic [DATAW-1:0] src_q[$];
  logic [DATAW-1:0] buf_q[$];
  int unsigned      stall_model;
  int               n_checks;
  int               n_pass;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock: drive inputs at negedge, compare outputs, then advance the model past the next posedge.
  task automatic step(input bit rdy, input bit gate, input bit fl, input bit rst);
    bit exp_pop;
    @(negedge clk);
    ready_out  = rdy;
    flush      = fl;
    reset      = rst;
    fifo_empty = gate || (src_q.size() == 0);
    fifo_data  = (src_q.size() != 0) ? src_q[0] : DATAW'($urandom);
    #1;
    exp_pop = !fifo_empty && (buf_q.size() < 2) && !fl && rst;
    chk("fifo_pop", {31'd0, fifo_pop}, {31'd0, exp_pop});
    chk("valid_out", {31'd0, valid_out}, (buf_q.size() > 0) ? 32'd1 : 32'd0);
    chk("count", {30'd0, count}, buf_q.size());
    if (buf_q.size() > 0) chk("data_out", {24'd0, data_out}, {24'd0, buf_q[0]});
`ifdef VX_POP_STAGE_PERF_EN
    chk("stall_cnt", stall_cnt, stall_model);
`endif
    if (!rst) begin
      buf_q.delete();
      stall_model = 0;
    end else begin
      if (buf_q.size() > 0 && !rdy) stall_model++;
      if (buf_q.size() > 0 && rdy) void'(buf_q.pop_front());
      if (fl) buf_q.delete();
      if (exp_pop) buf_q.push_back(src_q.pop_front());
    end
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    stall_model = 0;
    reset       = 1'b0;
    flush       = 1'b0;
    ready_out   = 1'b1;
    fifo_empty  = 1'b1;
    fifo_data   = '0;

    // Reset held with a non-empty source: nothing may be popped.
    src_q.push_back(8'hA0);
    repeat (3) step(1, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("rst_data_out", {24'd0, data_out}, 32'd0);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);

    // Streaming at full rate.
    for (int i = 0; i < 8; i++) src_q.push_back(8'h11 + 8'(i));
    repeat (12) step(1, 0, 0, 1);

    // Back-pressure until the skid fills, then release.
    for (int i = 0; i < 6; i++) src_q.push_back(8'h11 + 8'(i));
    repeat (3) step(0, 0, 0, 1);
    chk("bp_count", {30'd0, count}, 32'd2);
    chk("bp_data", {24'd0, data_out}, 32'h11);
    chk("bp_pop", {31'd0, fifo_pop}, 32'd0);
    repeat (2) step(0, 0, 0, 1);
    repeat (10) step(1, 0, 0, 1);

    // Flush while holding two entries.
    src_q.push_back(8'h21);
    src_q.push_back(8'h22);
    src_q.push_back(8'h23);
    repeat (3) step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    chk("flush_pop", {31'd0, fifo_pop}, 32'd0);
    step(0, 0, 0, 1);
    chk("post_flush_valid", {31'd0, valid_out}, 32'd0);
    chk("post_flush_pop", {31'd0, fifo_pop}, 32'd1);
    step(0, 0, 0, 1);
    chk("post_flush_data", {24'd0, data_out}, 32'h23);
    repeat (3) step(1, 0, 0, 1);

    // Source runs dry after a single item.
    src_q.push_back(8'h31);
    repeat (4) step(1, 0, 0, 1);
    chk("dry_valid", {31'd0, valid_out}, 32'd0);
    src_q.push_back(8'h32);
    repeat (2) step(1, 0, 0, 1);
    chk("refill_data", {24'd0, data_out}, 32'h32);

    // Sustained stall then flush: the stall counter must survive the flush.
    src_q.push_back(8'h41);
    step(0, 0, 0, 1);
    repeat (5) step(0, 1, 0, 1);
    step(0, 1, 1, 1);
    repeat (2) step(1, 1, 0, 1);

    // Random traffic, including mid-run resets and flushes.
    for (int i = 0; i < 1500; i++) begin
      while (src_q.size() < 4) src_q.push_back(DATAW'($urandom));
      step(($urandom % 3) != 0, ($urandom % 4) == 0, ($urandom % 40) == 0,
           ($urandom % 100) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vx_fifo_pop_stage.md
Name: vx_fifo_pop_stage

Overview:
- Downstream adapter for a FIFO queue. Drains the queue's head through its empty/pop/data_out interface and presents a registered valid/ready stream to the consumer.
- Holds a 2-entry skid buffer so that the FIFO pop is a function of registered state only. The consumer's ready never reaches fifo_pop combinationally.
- Sits between every FIFO queue instance and a pipeline stage that applies back-pressure.

Parameters:
- DATAW, 1, payload width in bits.
- PERF_W, 32, width of the stall counter (used only with the optional feature).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  DATAW  FIFO head data; valid whenever fifo_empty=0.
- fifo_pop  output  1  pop request to the FIFO.
- flush  input  1  synchronous discard of buffered entries.
- valid_out  output  1  output payload valid.
- ready_out  input  1  consumer accepts.
- data_out  output  DATAW  output payload.
- count  output  2  skid occupancy (0..2).
- stall_cnt  output  PERF_W  stall cycle count; present only with VX_POP_STAGE_PERF_EN.

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-low (reset=0 resets).
- Storage: head register (drives data_out) and spare register.
- State: EMPTY(0), ONE(1), TWO(2); count equals the state encoding.
- Reset: state=EMPTY, valid_out=0, fifo_pop=0, data_out=0, spare=0, count=0, stall_cnt=0.
- fifo_pop = fifo_empty=0 AND state!=TWO AND flush=0 AND reset=1. It depends on registered state only.
- valid_out = (state!=EMPTY); fire = valid_out AND ready_out.
- Transitions when flush=0:
  - EMPTY:
    - pop → ONE, head<=fifo_data.
    - else stay EMPTY.
  - ONE:
    - pop AND fire → ONE, head<=fifo_data.
    - pop AND NOT fire → TWO, spare<=fifo_data.
    - NOT pop AND fire → EMPTY.
    - else stay ONE.
  - TWO:
    - fire → ONE, head<=spare.
    - else hold; fifo_pop stays 0.
- flush=1:
  - Next state is EMPTY.
  - No pop occurs that cycle.
  - A fire in the flush cycle still counts as delivered.
  - Data registers are not cleared.
  - flush overrides all transitions.
- Latency: FIFO item popped in cycle t appears on valid_out/data_out in cycle t+1.
- Throughput: 1 item/cycle sustained while ready_out=1 and fifo_empty=0.
- Ordering: strict FIFO order; no loss or duplication under any ready_out pattern.
- data_out and valid_out are stable while valid_out=1 and ready_out=0.
- Reset mid-operation: all buffered entries are discarded; behaviour as at reset.
- Assertions (simulation only):
  - Never pop while fifo_empty=1.
  - count never exceeds 2.

Optional Feature:
- Macro: VX_POP_STAGE_PERF_EN.
- Defined:
  - stall_cnt port exists.
  - Increments by 1 each cycle with valid_out=1 AND ready_out=0; wraps modulo 2^PERF_W.
  - Cleared by reset; not cleared by flush.
- Undefined: port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 3 cycles with fifo_empty=0 → fifo_pop=0, valid_out=0, count=0 throughout. Release → fifo_pop=1 in the first cycle, valid_out=1 next cycle.
- Streaming: FIFO supplies 0x11..0x18, ready_out=1 constantly → fifo_pop every cycle. Outputs 0x11..0x18 in order on consecutive cycles; 8 transfers complete by cycle 9; count stays 1.
- Back-pressure: ready_out=0 after 0x11 is presented → count reaches 2, fifo_pop=0, data_out holds 0x11. Raise ready_out → 0x11, 0x12, 0x13... with no gap, duplicate or loss.
- Flush in TWO (head=0x21, spare=0x22) → next cycle valid_out=0, count=0, no pop in the flush cycle. Following cycle pops 0x23, which appears as the next output.
- Empty source: fifo_empty=1 with count=1 and ready_out=1 → one fire, then EMPTY. valid_out=0 until the FIFO goes non-empty.
- Perf (macro defined): valid_out=1 with ready_out=0 for 5 cycles → stall_cnt=5. After flush → still 5. Build without the macro → port absent and netlist compiles.
